// File: rtl/parking_gate_controller.sv
// Entry/exit barrier controller for the lot occupancy counter.
// Raw sensors are synchronised and debounced, and each passage yields one admission/release pulse.
module parking_gate_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OPEN_TIMEOUT    = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic entry_sensor,
  input  logic entry_pass,
  input  logic exit_sensor,
  input  logic exit_pass,
  input  logic full_signal,
  input  logic empty_signal,
  output logic car_arrival,
  output logic car_departure,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic lot_full_lamp
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = $clog2(OPEN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLEAR = 2'd2
  } gate_state_e;

  // Channel order: entry sense, entry pass, exit sense, exit pass.
  logic [3:0] raw;
  logic [3:0] filt;

  assign raw = {exit_pass, exit_sensor, entry_pass, entry_sensor};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cond
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             filt_q, filt_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        sync1_d = raw[gi];
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        // Only an unbroken run of DEBOUNCE_CYCLES mismatches moves the filter.
        if (sync2_q != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          filt_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          filt_q  <= filt_d;
          cnt_q   <= cnt_d;
        end
      end

      assign filt[gi] = filt_q;
    end
  endgenerate

  // Index 0 = entry direction, index 1 = exit direction.
  logic [1:0] sense;
  logic [1:0] pass;
  logic [1:0] permit;
  logic [1:0] due;
  logic [1:0] gate_up;

  assign sense  = {filt[2], filt[0]};
  assign pass   = {filt[3], filt[1]};
  assign permit = {~empty_signal, ~full_signal};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_gate
      gate_state_e      state_q, state_d;
      logic [TMR_W-1:0] timer_q, timer_d;
      logic             due_b;

      always_comb begin
        state_d = state_q;
        timer_d = '0;
        due_b   = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (sense[gi] && permit[gi]) begin
              state_d = ST_OPEN;
            end
          end
          ST_OPEN: begin
            if (pass[gi]) begin
              state_d = ST_CLEAR;
              due_b   = 1'b1;
            end else if (timer_q == TMR_LAST) begin
              state_d = ST_IDLE;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          ST_CLEAR: begin
            if (!pass[gi]) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end else begin
          state_q <= state_d;
          timer_q <= timer_d;
        end
      end

      assign due[gi]     = due_b;
      assign gate_up[gi] = (state_q != ST_IDLE);
    end
  endgenerate

  logic arrival_q, arrival_d;
  logic departure_q, departure_d;
  logic pending_q, pending_d;

  // The counter drops a departure that coincides with an arrival, so a clash defers it one cycle.
  always_comb begin
    arrival_d   = due[0];
    departure_d = pending_q | (due[1] & ~due[0]);
    pending_d   = due[1] & due[0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arrival_q   <= 1'b0;
      departure_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      arrival_q   <= arrival_d;
      departure_q <= departure_d;
      pending_q   <= pending_d;
    end
  end

  assign car_arrival     = arrival_q;
  assign car_departure   = departure_q;
  assign entry_gate_open = gate_up[0];
  assign exit_gate_open  = gate_up[1];
  assign lot_full_lamp   = ~gate_up[0] & sense[0] & full_signal;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller (D=4, T=32): latency, pulses, refusal, timeout,
// arrival/departure clash, debounce rejection and asynchronous reset.
module tb_parking_gate_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic entry_sensor = 1'b0, entry_pass = 1'b0, exit_sensor = 1'b0, exit_pass = 1'b0;
  logic full_signal = 1'b0, empty_signal = 1'b0;
  logic car_arrival, car_departure, entry_gate_open, exit_gate_open, lot_full_lamp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int arr_cnt = 0, dep_cnt = 0, both_cnt = 0, ent_hi_cnt = 0;
  int last_arr = 0, last_dep = 0;
  int base = 0;
  int hi_cnt = 0;

  parking_gate_controller #(
    .DEBOUNCE_CYCLES(4),
    .OPEN_TIMEOUT   (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .entry_sensor   (entry_sensor),
    .entry_pass     (entry_pass),
    .exit_sensor    (exit_sensor),
    .exit_pass      (exit_pass),
    .full_signal    (full_signal),
    .empty_signal   (empty_signal),
    .car_arrival    (car_arrival),
    .car_departure  (car_departure),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open (exit_gate_open),
    .lot_full_lamp  (lot_full_lamp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance n rising edges; observe 1 time unit after each edge and tally output activity.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (car_arrival === 1'b1) begin
        arr_cnt++;
        last_arr = cyc;
      end
      if (car_departure === 1'b1) begin
        dep_cnt++;
        last_dep = cyc;
      end
      if (car_arrival === 1'b1 && car_departure === 1'b1) both_cnt++;
      if (entry_gate_open === 1'b1) ent_hi_cnt++;
    end
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_entry_gate", entry_gate_open, 0);
    chk("rst_exit_gate", exit_gate_open, 0);
    chk("rst_pulses", {car_arrival, car_departure}, 0);
    chk("rst_lamp", lot_full_lamp, 0);
    reset = 1'b0;
    step(2);

    // 1: open latency, single arrival pulse, close latency
    entry_sensor = 1'b1;
    step(6);
    chk("t1_gate_at_6", entry_gate_open, 0);
    step(1);
    chk("t1_gate_at_7", entry_gate_open, 1);
    entry_sensor = 1'b0;
    entry_pass = 1'b1;
    base = cyc;
    step(10);
    entry_pass = 1'b0;
    chk("t1_arrival_count", arr_cnt, 1);
    chk("t1_arrival_step", last_arr - base, 7);
    step(6);
    chk("t1_gate_6_after_fall", entry_gate_open, 1);
    step(1);
    chk("t1_gate_7_after_fall", entry_gate_open, 0);
    step(10);
    chk("t1_no_extra_arrival", arr_cnt, 1);
    chk("t1_no_departure", dep_cnt, 0);

    // 2: refusal when full, lamp, then admission when full clears
    full_signal = 1'b1;
    entry_sensor = 1'b1;
    step(10);
    chk("t2_gate_refused", entry_gate_open, 0);
    chk("t2_lamp_on", lot_full_lamp, 1);
    full_signal = 1'b0;
    step(1);
    chk("t2_gate_after_unfull", entry_gate_open, 1);
    chk("t2_lamp_off", lot_full_lamp, 0);
    entry_sensor = 1'b0;
    step(40);
    chk("t2_timed_out", entry_gate_open, 0);

    // 3: timeout holds the gate exactly 32 cycles, then reopens with sensor held
    entry_sensor = 1'b1;
    step(7);
    chk("t3_gate_open", entry_gate_open, 1);
    hi_cnt = 0;
    for (int i = 0; i < 31; i++) begin
      step(1);
      if (entry_gate_open === 1'b1) hi_cnt++;
    end
    chk("t3_high_cycles", hi_cnt, 31);
    step(1);
    chk("t3_gate_dropped", entry_gate_open, 0);
    step(1);
    chk("t3_gate_reopen", entry_gate_open, 1);
    chk("t3_no_pulse", arr_cnt, 1);
    entry_sensor = 1'b0;
    step(45);
    chk("t3_final_closed", entry_gate_open, 0);

    // 4a: exit-only passage gives an undeferred departure
    exit_sensor = 1'b1;
    step(7);
    chk("t4a_exit_gate", exit_gate_open, 1);
    exit_sensor = 1'b0;
    exit_pass = 1'b1;
    base = cyc;
    step(10);
    exit_pass = 1'b0;
    chk("t4a_dep_count", dep_cnt, 1);
    chk("t4a_dep_step", last_dep - base, 7);
    step(10);

    // 4b: aligned passages -> arrival at N, departure at N+1
    entry_sensor = 1'b1;
    exit_sensor = 1'b1;
    step(7);
    chk("t4b_both_gates", {entry_gate_open, exit_gate_open}, 2'b11);
    entry_sensor = 1'b0;
    exit_sensor = 1'b0;
    entry_pass = 1'b1;
    exit_pass = 1'b1;
    base = cyc;
    step(12);
    entry_pass = 1'b0;
    exit_pass = 1'b0;
    chk("t4b_arr_step", last_arr - base, 7);
    chk("t4b_dep_step", last_dep - base, 8);
    chk("t4b_counts", {arr_cnt[7:0], dep_cnt[7:0]}, {8'd2, 8'd2});
    chk("t4b_never_both", both_cnt, 0);
    step(10);
    chk("t4b_gates_closed", {entry_gate_open, exit_gate_open}, 0);

    // 5: short blip and toggling never open the gate
    hi_cnt = ent_hi_cnt;
    entry_sensor = 1'b1;
    step(3);
    entry_sensor = 1'b0;
    step(12);
    chk("t5_short_blip", ent_hi_cnt - hi_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      entry_sensor = ~entry_sensor;
      step(1);
    end
    entry_sensor = 1'b0;
    step(12);
    chk("t5_toggle", ent_hi_cnt - hi_cnt, 0);
    chk("t5_no_pulses", {arr_cnt[7:0], dep_cnt[7:0]}, {8'd2, 8'd2});

    // 6: async reset while open, then exit refused when empty
    entry_sensor = 1'b1;
    exit_sensor = 1'b1;
    step(7);
    chk("t6_open_before_reset", {entry_gate_open, exit_gate_open}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_drop", {entry_gate_open, exit_gate_open}, 0);
    entry_sensor = 1'b0;
    exit_sensor = 1'b0;
    step(2);
    reset = 1'b0;
    empty_signal = 1'b1;
    exit_sensor = 1'b1;
    step(12);
    chk("t6_exit_refused", exit_gate_open, 0);
    chk("t6_no_pulses", {arr_cnt[7:0], dep_cnt[7:0]}, {8'd2, 8'd2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
